// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock downsampler.
// Per-channel state is stored at a fixed maximum divisor width; narrower builds zero the upper bits.
package clk_div_pkg;

   localparam int width_d    = 4;
   localparam int channels_d = 4;
   localparam int div_max_w  = 16;

   typedef struct packed {
      logic [div_max_w-1:0] div;
      logic [div_max_w-1:0] shadow;
      logic [div_max_w-1:0] cnt;
      logic                 clk_r;
      logic                 pending;
   } chan_state_t;

   // Channel-select width; never zero so a single-channel build still has a select port.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divided-clock channel: counter, shadow divisor, and the apply-at-period-end rule.
// Latency: a new divisor lands at the next 1->0 output toggle (immediately when stopped); write is 1 cycle.
// Backpressure: the parent must only assert wr_i while pending_o is low. Optional CLK_DIV_PHASE_ALIGN_EN adds sync_i.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int width_p = width_d
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               en_i,
   input  logic               wr_i,
   input  logic [width_p-1:0] wr_div_i,
`ifdef CLK_DIV_PHASE_ALIGN_EN
   input  logic               sync_i,
`endif
   output logic               clk_r_o,
   output logic               tick_o,
   output logic               pending_o
);

   chan_state_t          st;
   logic                 tick_r;
   logic [div_max_w-1:0] wr_div_ext;
   logic                 sync_hit;
   logic                 running;
   logic                 at_end;

   always_comb begin
      wr_div_ext                = '0;
      wr_div_ext[width_p-1:0]   = wr_div_i;
   end

`ifdef CLK_DIV_PHASE_ALIGN_EN
   assign sync_hit = sync_i & en_i;
`else
   assign sync_hit = 1'b0;
`endif

   // A disabled channel keeps running until its high phase is finished.
   assign running = en_i | st.clk_r;
   assign at_end  = (st.cnt == st.div);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         st     <= '0;
         tick_r <= 1'b0;
      end else begin
         tick_r <= 1'b0;
         if (wr_i) begin
            st.shadow  <= wr_div_ext;
            st.pending <= 1'b1;
         end
         if (sync_hit) begin
            st.cnt   <= '0;
            st.clk_r <= 1'b0;
            if (st.pending) begin
               st.div     <= st.shadow;
               st.pending <= 1'b0;
            end
         end else if (running) begin
            if (at_end) begin
               st.cnt   <= '0;
               st.clk_r <= ~st.clk_r;
               tick_r   <= ~st.clk_r;
               // Falling toggle closes a full period, the only safe point to swap divisors.
               if (st.clk_r && st.pending) begin
                  st.div     <= st.shadow;
                  st.pending <= 1'b0;
               end
            end else begin
               st.cnt <= st.cnt + div_max_w'(1);
            end
         end else begin
            st.cnt <= '0;
            if (st.pending) begin
               st.div     <= st.shadow;
               st.pending <= 1'b0;
            end
         end
      end
   end

   assign clk_r_o   = st.clk_r;
   assign tick_o    = tick_r;
   assign pending_o = st.pending;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock downsampler with glitch-free runtime divisor updates.
// Latency: outputs registered; config write takes 1 cycle, divisor applies at the end of the current period.
// Backpressure: cfg_ready_o drops while the addressed channel holds a pending divisor. CLK_DIV_PHASE_ALIGN_EN adds sync_i.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int width_p    = width_d,
   parameter int channels_p = channels_d
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic [channels_p-1:0]         en_i,
   input  logic                          cfg_v_i,
   input  logic [ch_w(channels_p)-1:0]   cfg_ch_i,
   input  logic [width_p-1:0]            cfg_div_i,
`ifdef CLK_DIV_PHASE_ALIGN_EN
   input  logic                          sync_i,
`endif
   output logic                          cfg_ready_o,
   output logic [channels_p-1:0]         clk_r_o,
   output logic [channels_p-1:0]         tick_o,
   output logic [channels_p-1:0]         pending_o
);

   localparam int ch_w_lp     = ch_w(channels_p);
   localparam int ch_slots_lp = 1 << ch_w_lp;

   // Unpopulated select codes read as never-pending, so writes to them are accepted and dropped.
   logic [ch_slots_lp-1:0] pend_slots;
   logic                   cfg_acc;

   always_comb begin
      pend_slots                   = '0;
      pend_slots[channels_p-1:0]   = pending_o;
   end

   assign cfg_ready_o = ~pend_slots[cfg_ch_i];
   assign cfg_acc     = cfg_v_i & cfg_ready_o;

   for (genvar c = 0; c < channels_p; c++) begin : g_chan
      logic wr;
      assign wr = cfg_acc & (cfg_ch_i == ch_w_lp'(c));

      clk_div_chan #(
         .width_p (width_p)
      ) u_chan (
         .clk_i     (clk_i),
         .reset_n_i (reset_n_i),
         .en_i      (en_i[c]),
         .wr_i      (wr),
         .wr_div_i  (cfg_div_i),
`ifdef CLK_DIV_PHASE_ALIGN_EN
         .sync_i    (sync_i),
`endif
         .clk_r_o   (clk_r_o[c]),
         .tick_o    (tick_o[c]),
         .pending_o (pending_o[c])
      );
   end

endmodule
